// File: rtl/flame_ctrl_if.sv
// Drop handshake, frame tick and flame-renderer signals shared by flame_ctrl and its requester.
interface flame_ctrl_if;
    logic       frame_tick;
    logic       drop_req;
    logic [9:0] drop_x;
    logic [9:0] drop_y;
    logic       drop_ack;
    logic       busy;
    logic       flame_active;
    logic [9:0] flame_centerX;
    logic [9:0] flame_centerY;
    logic [2:0] sprite_num;
    logic       explode_done;

    modport master (
        output frame_tick, drop_req, drop_x, drop_y,
        input  drop_ack, busy, flame_active, flame_centerX, flame_centerY,
               sprite_num, explode_done
    );

    modport slave (
        input  frame_tick, drop_req, drop_x, drop_y,
        output drop_ack, busy, flame_active, flame_centerX, flame_centerY,
               sprite_num, explode_done
    );
endinterface

// File: rtl/flame_ctrl.sv
// Bomb fuse / explosion sequencer driving the flame sprite renderer.
// Define FLAME_PINGPONG_EN for a 0..N-1..0 sprite sequence instead of 0..N-1.
module flame_ctrl #(
    parameter int unsigned FUSE_FRAMES       = 120,
    parameter int unsigned FRAMES_PER_SPRITE = 6,
    parameter int unsigned NUM_SPRITES       = 5
) (
    input  logic        clk,
    input  logic        reset,
    flame_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FUSE    = 2'd1,
        EXPLODE = 2'd2
    } state_e;

    localparam logic [7:0] FUSE_LOAD   = 8'(FUSE_FRAMES);
    localparam logic [3:0] SUB_LOAD    = 4'(FRAMES_PER_SPRITE);
    localparam logic [2:0] LAST_SPRITE = 3'(NUM_SPRITES - 1);

    state_e     state_q, state_d;
    logic [7:0] fuse_q, fuse_d;
    logic [3:0] sub_q, sub_d;
    logic [2:0] sprite_q, sprite_d;
    logic [9:0] cx_q, cx_d;
    logic [9:0] cy_q, cy_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       active_q, active_d;
    logic       done_q, done_d;
    logic       finish_s;
`ifdef FLAME_PINGPONG_EN
    logic       dir_q, dir_d;
`endif

    // Clamp to the limit, otherwise snap down to the 32-pixel tile grid (limits are tile aligned).
    function automatic logic [9:0] snap_coord(input logic [9:0] v, input logic [9:0] lim);
        if (v >= lim) begin
            snap_coord = lim;
        end else begin
            snap_coord = {v[9:5], 5'b00000};
        end
    endfunction

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d  = state_q;
        fuse_d   = fuse_q;
        sub_d    = sub_q;
        sprite_d = sprite_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        finish_s = 1'b0;
`ifdef FLAME_PINGPONG_EN
        dir_d    = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.drop_req) begin
                    state_d = FUSE;
                    ack_d   = 1'b1;
                    fuse_d  = FUSE_LOAD;
                    cx_d    = snap_coord(bus.drop_x, 10'd768);
                    cy_d    = snap_coord(bus.drop_y, 10'd544);
                end else begin
                    state_d = IDLE;
                end
            end
            FUSE: begin
                if (bus.frame_tick && (fuse_q == 8'd1)) begin
                    state_d  = EXPLODE;
                    fuse_d   = 8'd0;
                    sub_d    = SUB_LOAD;
                    sprite_d = 3'd0;
`ifdef FLAME_PINGPONG_EN
                    dir_d    = 1'b0;
`endif
                end else if (bus.frame_tick) begin
                    fuse_d = fuse_q - 8'd1;
                end else begin
                    state_d = FUSE;
                end
            end
            EXPLODE: begin
                if (bus.frame_tick && (sub_q == 4'd1)) begin
                    sub_d = SUB_LOAD;
`ifdef FLAME_PINGPONG_EN
                    // Rising leg turns around at the last sprite; falling leg ends after sprite 0.
                    if (!dir_q && (sprite_q != LAST_SPRITE)) begin
                        sprite_d = sprite_q + 3'd1;
                    end else if (sprite_q == 3'd0) begin
                        finish_s = 1'b1;
                    end else begin
                        dir_d    = 1'b1;
                        sprite_d = sprite_q - 3'd1;
                    end
`else
                    if (sprite_q == LAST_SPRITE) begin
                        finish_s = 1'b1;
                    end else begin
                        sprite_d = sprite_q + 3'd1;
                    end
`endif
                end else if (bus.frame_tick) begin
                    sub_d = sub_q - 4'd1;
                end else begin
                    state_d = EXPLODE;
                end
                if (finish_s) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    sprite_d = 3'd0;
                    sub_d    = 4'd0;
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d   = (state_d != IDLE);
        active_d = (state_d == EXPLODE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            fuse_q   <= 8'd0;
            sub_q    <= 4'd0;
            sprite_q <= 3'd0;
            cx_q     <= 10'd0;
            cy_q     <= 10'd0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef FLAME_PINGPONG_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fuse_q   <= fuse_d;
            sub_q    <= sub_d;
            sprite_q <= sprite_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            active_q <= active_d;
            done_q   <= done_d;
`ifdef FLAME_PINGPONG_EN
            dir_q    <= dir_d;
`endif
        end
    end

    assign bus.drop_ack      = ack_q;
    assign bus.busy          = busy_q;
    assign bus.flame_active  = active_q;
    assign bus.flame_centerX = cx_q;
    assign bus.flame_centerY = cy_q;
    assign bus.sprite_num    = sprite_q;
    assign bus.explode_done  = done_q;

endmodule

// File: tb/tb_flame_ctrl.sv
// Scoreboard bench for flame_ctrl with FUSE_FRAMES=3, FRAMES_PER_SPRITE=2, NUM_SPRITES=5.
`timescale 1ns/1ps
module tb_flame_ctrl;
    localparam int FUSE = 3;
    localparam int FPS  = 2;
    localparam int NSPR = 5;
`ifdef FLAME_PINGPONG_EN
    localparam int NSTEPS = 2 * NSPR - 1;
`else
    localparam int NSTEPS = NSPR;
`endif

    logic clk = 1'b0;
    logic reset;
    flame_ctrl_if bus_if ();

    flame_ctrl #(
        .FUSE_FRAMES(FUSE),
        .FRAMES_PER_SPRITE(FPS),
        .NUM_SPRITES(NSPR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    logic [9:0] exp_cx_q[$];
    logic [9:0] exp_cy_q[$];
    logic [2:0] exp_spr_q[$];
    logic [9:0] last_cx, last_cy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus_if.frame_tick = 1'b1;
        step();
        bus_if.frame_tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"},    32'(bus_if.drop_ack), 32'd0);
        check_eq({tag, "_busy"},   32'(bus_if.busy), 32'd0);
        check_eq({tag, "_active"}, 32'(bus_if.flame_active), 32'd0);
        check_eq({tag, "_cx"},     32'(bus_if.flame_centerX), 32'd0);
        check_eq({tag, "_cy"},     32'(bus_if.flame_centerY), 32'd0);
        check_eq({tag, "_sprite"}, 32'(bus_if.sprite_num), 32'd0);
        check_eq({tag, "_done"},   32'(bus_if.explode_done), 32'd0);
    endtask

    task automatic push_coords(input logic [9:0] x, input logic [9:0] y);
        exp_cx_q.push_back((x > 10'd768) ? 10'd768 : (x / 10'd32) * 10'd32);
        exp_cy_q.push_back((y > 10'd544) ? 10'd544 : (y / 10'd32) * 10'd32);
    endtask

    task automatic check_accept();
        check_eq("drop_ack", 32'(bus_if.drop_ack), 32'd1);
        check_eq("busy_fuse", 32'(bus_if.busy), 32'd1);
        check_eq("active_fuse0", 32'(bus_if.flame_active), 32'd0);
        if (exp_cx_q.size() > 0) begin
            last_cx = exp_cx_q.pop_front();
            last_cy = exp_cy_q.pop_front();
            check_eq("centerX", 32'(bus_if.flame_centerX), 32'(last_cx));
            check_eq("centerY", 32'(bus_if.flame_centerY), 32'(last_cy));
        end else begin
            check_eq("coord_queue_empty", 32'd0, 32'd1);
        end
        step();
        check_eq("ack_one_cycle", 32'(bus_if.drop_ack), 32'd0);
    endtask

    task automatic do_drop(input logic [9:0] x, input logic [9:0] y, input logic tick_too);
        int budget;
        push_coords(x, y);
        bus_if.drop_req   = 1'b1;
        bus_if.drop_x     = x;
        bus_if.drop_y     = y;
        bus_if.frame_tick = tick_too;
        budget = 0;
        do begin
            step();
            bus_if.drop_req   = 1'b0;
            bus_if.frame_tick = 1'b0;
            budget++;
        end while (!bus_if.drop_ack && budget < 4);
        check_accept();
    endtask

    task automatic poke_drop(input string tag);
        bus_if.drop_req = 1'b1;
        bus_if.drop_x   = 10'd500;
        bus_if.drop_y   = 10'd300;
        step();
        bus_if.drop_req = 1'b0;
        check_eq({tag, "_no_ack"}, 32'(bus_if.drop_ack), 32'd0);
        step();
        check_eq({tag, "_no_ack2"}, 32'(bus_if.drop_ack), 32'd0);
        check_eq({tag, "_cx_held"}, 32'(bus_if.flame_centerX), 32'(last_cx));
        check_eq({tag, "_cy_held"}, 32'(bus_if.flame_centerY), 32'(last_cy));
    endtask

    task automatic fuse_phase(input bit poke);
        for (int i = 1; i <= FUSE; i++) begin
            if (poke && i == 2) poke_drop("fuse_poke");
            tick();
            check_eq("active_after_fuse_tick", 32'(bus_if.flame_active), (i == FUSE) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic explode_phase(input bit poke, input int stop_after);
        int n;
        for (int s = 0; s < NSTEPS; s++) begin
            int v;
            v = s;
            if (s >= NSPR) v = 2 * (NSPR - 1) - s;
            for (int r = 0; r < FPS; r++) exp_spr_q.push_back(3'(v));
        end
        n = 0;
        while (exp_spr_q.size() > 0 && n < stop_after) begin
            check_eq("sprite_num", 32'(bus_if.sprite_num), 32'(exp_spr_q.pop_front()));
            check_eq("active_explode", 32'(bus_if.flame_active), 32'd1);
            if (poke && n == 3) poke_drop("explode_poke");
            tick();
            n++;
        end
        if (exp_spr_q.size() == 0) begin
            check_eq("explode_done", 32'(bus_if.explode_done), 32'd1);
            check_eq("active_end", 32'(bus_if.flame_active), 32'd0);
            check_eq("busy_end", 32'(bus_if.busy), 32'd0);
            check_eq("sprite_end", 32'(bus_if.sprite_num), 32'd0);
            step();
            check_eq("done_one_cycle", 32'(bus_if.explode_done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus_if.frame_tick = 1'b0;
        bus_if.drop_req   = 1'b0;
        bus_if.drop_x     = 10'd0;
        bus_if.drop_y     = 10'd0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        tick();
        check_eq("idle_tick_busy", 32'(bus_if.busy), 32'd0);
        check_eq("idle_tick_active", 32'(bus_if.flame_active), 32'd0);

        // Basic explosion with ignored drops during fuse and explosion.
        do_drop(10'd100, 10'd70, 1'b0);
        fuse_phase(1'b1);
        explode_phase(1'b1, 100);

        // Clamped coordinates.
        do_drop(10'd1000, 10'd599, 1'b0);
        fuse_phase(1'b0);
        explode_phase(1'b0, 100);

        // Tick coincident with the accepting edge must not count.
        do_drop(10'd200, 10'd300, 1'b1);
        fuse_phase(1'b0);
        explode_phase(1'b0, 100);

        // Reset mid-explosion, then a drop pending across reset release.
        do_drop(10'd40, 10'd40, 1'b0);
        fuse_phase(1'b0);
        explode_phase(1'b0, 3);
        exp_spr_q.delete();
        reset = 1'b1;
        #2;
        check_all_zero("reset_mid");
        push_coords(10'd333, 10'd33);
        bus_if.drop_req = 1'b1;
        bus_if.drop_x   = 10'd333;
        bus_if.drop_y   = 10'd33;
        #2;
        reset = 1'b0;
        step();
        bus_if.drop_req = 1'b0;
        check_accept();
        fuse_phase(1'b0);
        explode_phase(1'b0, 100);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
